// File: rtl/tiny_vpu_pkg.sv
// Shared types and instruction decode helpers for the tiny vector-processing unit.
// Flag positions are fixed; the address field width is chosen by the instantiating module.
package tiny_vpu_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam int unsigned BIT_LOAD_LEFT  = 31;
  localparam int unsigned BIT_LOAD_TOP   = 30;
  localparam int unsigned BIT_SWAP_LEFT  = 29;
  localparam int unsigned BIT_SWAP_TOP   = 28;
  localparam int unsigned BIT_SHIFT_LEFT = 27;
  localparam int unsigned BIT_SHIFT_TOP  = 26;
  localparam int unsigned BIT_ACC_LOAD   = 25;
  localparam int unsigned BIT_ACC_OUT    = 24;
  localparam int unsigned BIT_NOP        = 20;
  localparam int unsigned BIT_CLR_ACC    = 17;
  localparam int unsigned BIT_CLR_ARRAY  = 16;
  localparam int unsigned BIT_CLR_LEFT   = 15;
  localparam int unsigned BIT_CLR_TOP    = 14;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    MOP_LEFT = 2'd0,
    MOP_TOP  = 2'd1,
    MOP_OUT  = 2'd2
  } mem_op_e;

  typedef struct packed {
    logic load_left;
    logic load_top;
    logic swap_left;
    logic swap_top;
    logic shift_left;
    logic shift_top;
    logic acc_load;
    logic acc_out;
    logic clr_acc;
    logic clr_array;
    logic clr_left;
    logic clr_top;
  } instr_flags_t;

  function automatic instr_flags_t decode_flags(input logic [INSTR_W-1:0] instr);
    instr_flags_t f;
    f.load_left  = instr[BIT_LOAD_LEFT];
    f.load_top   = instr[BIT_LOAD_TOP];
    f.swap_left  = instr[BIT_SWAP_LEFT];
    f.swap_top   = instr[BIT_SWAP_TOP];
    f.shift_left = instr[BIT_SHIFT_LEFT];
    f.shift_top  = instr[BIT_SHIFT_TOP];
    f.acc_load   = instr[BIT_ACC_LOAD];
    f.acc_out    = instr[BIT_ACC_OUT];
    f.clr_acc    = instr[BIT_CLR_ACC];
    f.clr_array  = instr[BIT_CLR_ARRAY];
    f.clr_left   = instr[BIT_CLR_LEFT];
    f.clr_top    = instr[BIT_CLR_TOP];
    return f;
  endfunction

  function automatic logic needs_mem(input instr_flags_t f);
    return f.load_left | f.load_top | f.acc_out;
  endfunction

  // MEM groups always run left load, then top load, then accumulator store.
  function automatic mem_op_e first_mem_op(input instr_flags_t f);
    if (f.load_left) return MOP_LEFT;
    if (f.load_top)  return MOP_TOP;
    return MOP_OUT;
  endfunction

endpackage

// File: rtl/dpram.sv
// Simple two-port RAM: one write port, one registered read port (1-cycle latency).
// Contents are not reset.
module dpram #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/tiny_fsm_ctrl.sv
// Instruction sequencer for the tiny VPU: fetches from an async ROM, decodes flag bits
// and drives the data DPRAM, operand buffers and MAC accumulators.
module tiny_fsm_ctrl
  import tiny_vpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned MATRIX_SIZE   = 8,
  parameter int unsigned ACC_WIDTH     = 32,
  parameter int unsigned DP_ADDR_WIDTH = 10,
  parameter int unsigned INSTR_WIDTH   = 32,
  parameter int unsigned INSTR_DEPTH   = 256
) (
  input  logic                           clk,
  input  logic                           fsm_rst,
  input  logic                           step,
  input  logic                           run,
  input  logic                           halt,
  output logic [$clog2(INSTR_DEPTH)-1:0] rd_addr,
  input  logic [INSTR_WIDTH-1:0]         rd_data,
  input  logic                           mem_ext_en,
  output logic [$clog2(INSTR_DEPTH)-1:0] pc_out,
  output logic [INSTR_WIDTH-1:0]         curr_instr_out,
  output logic [INSTR_WIDTH-1:0]         next_instr_out,
  output logic [2:0]                     state_out
);

  localparam int unsigned PC_W   = $clog2(INSTR_DEPTH);
  localparam int unsigned BEAT_W = $clog2(MATRIX_SIZE + 1);
  localparam int unsigned PROD_W = 2 * DATA_WIDTH;

  typedef logic [MATRIX_SIZE-1:0][DATA_WIDTH-1:0] lanes_t;
  typedef logic [MATRIX_SIZE-1:0][ACC_WIDTH-1:0]  accs_t;

  state_e                   state_q, state_d;
  logic [PC_W-1:0]          pc_q, pc_d;
  logic [INSTR_WIDTH-1:0]   curr_instr_q, curr_instr_d;
  logic [INSTR_WIDTH-1:0]   next_instr_q, next_instr_d;
  logic                     halt_pend_q, halt_pend_d;
  mem_op_e                  mem_op_q, mem_op_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  lanes_t                   left_act_q, left_act_d;
  lanes_t                   left_sh_q, left_sh_d;
  lanes_t                   top_act_q, top_act_d;
  lanes_t                   top_sh_q, top_sh_d;
  accs_t                    acc_q, acc_d;

  instr_flags_t             flags;
  logic [PC_W-1:0]          pc_plus1;
  logic [DP_ADDR_WIDTH-1:0] beat_addr;
  logic                     last_beat;
  logic                     more_ops;
  mem_op_e                  next_op;
  lanes_t                   swap_tmp;
  logic [PROD_W-1:0]        prod;

  logic                     dp_we_c;
  logic [DP_ADDR_WIDTH-1:0] dp_waddr_c;
  logic [DATA_WIDTH-1:0]    dp_wdata_c;
  logic [DP_ADDR_WIDTH-1:0] dp_raddr_c;
  logic [DATA_WIDTH-1:0]    dp_rdata;

  dpram #(
    .WIDTH      (DATA_WIDTH),
    .ADDR_WIDTH (DP_ADDR_WIDTH)
  ) DPRAM (
    .clk   (clk),
    .we    (dp_we_c),
    .waddr (dp_waddr_c),
    .wdata (dp_wdata_c),
    .raddr (dp_raddr_c),
    .rdata (dp_rdata)
  );

  assign flags     = decode_flags(INSTR_W'(curr_instr_q));
  assign pc_plus1  = (pc_q == PC_W'(INSTR_DEPTH - 1)) ? '0 : pc_q + PC_W'(1);
  assign beat_addr = curr_instr_q[DP_ADDR_WIDTH-1:0] + DP_ADDR_WIDTH'(beat_q);
  assign last_beat = (beat_q == BEAT_W'(MATRIX_SIZE));

  // Which MEM group follows the current one, if any.
  always_comb begin
    more_ops = 1'b0;
    next_op  = MOP_OUT;
    if (mem_op_q == MOP_LEFT && flags.load_top) begin
      more_ops = 1'b1;
      next_op  = MOP_TOP;
    end else if (mem_op_q != MOP_OUT && flags.acc_out) begin
      more_ops = 1'b1;
      next_op  = MOP_OUT;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    curr_instr_d = curr_instr_q;
    next_instr_d = next_instr_q;
    halt_pend_d  = halt_pend_q;
    mem_op_d     = mem_op_q;
    beat_d       = beat_q;
    left_act_d   = left_act_q;
    left_sh_d    = left_sh_q;
    top_act_d    = top_act_q;
    top_sh_d     = top_sh_q;
    acc_d        = acc_q;
    swap_tmp     = '0;
    prod         = '0;
    rd_addr      = pc_q;
    dp_we_c      = 1'b0;
    dp_waddr_c   = beat_addr;
    dp_wdata_c   = '0;
    dp_raddr_c   = beat_addr;

    case (state_q)
      ST_IDLE: begin
        halt_pend_d = 1'b0;
        if ((run || step) && !halt) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        curr_instr_d = rd_data;
        state_d      = ST_DECODE;
      end

      ST_DECODE: begin
        rd_addr      = pc_plus1;
        next_instr_d = rd_data;
        if (needs_mem(flags)) begin
          if (!mem_ext_en) begin
            state_d  = ST_MEM;
            mem_op_d = first_mem_op(flags);
            beat_d   = '0;
          end
        end else begin
          state_d = ST_EXEC;
        end
      end

      // Beat k issues address base+k; read data for lane k-1 lands on beat k.
      ST_MEM: begin
        case (mem_op_q)
          MOP_LEFT: begin
            for (int i = 0; i < int'(MATRIX_SIZE); i++)
              if (beat_q == BEAT_W'(i + 1)) left_sh_d[i] = dp_rdata;
          end
          MOP_TOP: begin
            for (int i = 0; i < int'(MATRIX_SIZE); i++)
              if (beat_q == BEAT_W'(i + 1)) top_sh_d[i] = dp_rdata;
          end
          default: begin
            dp_we_c = !last_beat;
            for (int i = 0; i < int'(MATRIX_SIZE); i++)
              if (beat_q == BEAT_W'(i)) dp_wdata_c = acc_q[i][DATA_WIDTH-1:0];
          end
        endcase
        if (last_beat) begin
          beat_d = '0;
          if (more_ops) mem_op_d = next_op;
          else          state_d  = ST_EXEC;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end

      // Clears, then swaps, then shifts, then multiply-accumulate on the active buffers.
      ST_EXEC: begin
        if (flags.clr_left) begin
          left_act_d = '0;
          left_sh_d  = '0;
        end
        if (flags.clr_top) begin
          top_act_d = '0;
          top_sh_d  = '0;
        end
        if (flags.clr_acc || flags.clr_array) acc_d = '0;
        if (flags.swap_left) begin
          swap_tmp   = left_act_d;
          left_act_d = left_sh_d;
          left_sh_d  = swap_tmp;
        end
        if (flags.swap_top) begin
          swap_tmp  = top_act_d;
          top_act_d = top_sh_d;
          top_sh_d  = swap_tmp;
        end
        if (flags.shift_left) left_act_d = {left_act_d[MATRIX_SIZE-2:0], DATA_WIDTH'(0)};
        if (flags.shift_top)  top_act_d  = {top_act_d[MATRIX_SIZE-2:0], DATA_WIDTH'(0)};
        if (flags.acc_load) begin
          for (int i = 0; i < int'(MATRIX_SIZE); i++) begin
            prod     = PROD_W'(left_act_d[i]) * PROD_W'(top_act_d[i]);
            acc_d[i] = acc_d[i] + ACC_WIDTH'(prod);
          end
        end
        state_d = ST_WB;
      end

      ST_WB: begin
        pc_d        = pc_plus1;
        halt_pend_d = 1'b0;
        if (run && !halt && !halt_pend_q) state_d = ST_FETCH;
        else                              state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // A halt seen mid-instruction is remembered until the next instruction boundary.
    if (halt && (state_q == ST_FETCH || state_q == ST_DECODE ||
                 state_q == ST_MEM   || state_q == ST_EXEC))
      halt_pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (fsm_rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      curr_instr_q <= '0;
      next_instr_q <= '0;
      halt_pend_q  <= 1'b0;
      mem_op_q     <= MOP_LEFT;
      beat_q       <= '0;
      left_act_q   <= '0;
      left_sh_q    <= '0;
      top_act_q    <= '0;
      top_sh_q     <= '0;
      acc_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      curr_instr_q <= curr_instr_d;
      next_instr_q <= next_instr_d;
      halt_pend_q  <= halt_pend_d;
      mem_op_q     <= mem_op_d;
      beat_q       <= beat_d;
      left_act_q   <= left_act_d;
      left_sh_q    <= left_sh_d;
      top_act_q    <= top_act_d;
      top_sh_q     <= top_sh_d;
      acc_q        <= acc_d;
    end
  end

  assign state_out      = state_q;
  assign pc_out         = pc_q;
  assign curr_instr_out = curr_instr_q;
  assign next_instr_out = next_instr_q;

endmodule

// File: tb/tb_tiny_fsm_ctrl.sv
// Directed bench for tiny_fsm_ctrl: sequencing, loads/swaps, MAC + store, halt,
// DPRAM-reservation stall, PC wrap and mid-MEM reset.
module tb_tiny_fsm_ctrl;

  localparam int unsigned ID = 256;
  localparam logic [31:0] I_NOP = 32'h0010_0000;
  localparam logic [31:0] I_LL  = 32'h8000_0001;

  logic        clk = 1'b0;
  logic        fsm_rst, step, run, halt, mem_ext_en;
  logic [7:0]  rd_addr, pc_out;
  logic [31:0] rd_data, curr_instr_out, next_instr_out;
  logic [2:0]  state_out;
  logic [31:0] rom [ID];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc;
  int max_pc;
  int exp_lat [6] = '{13, 4, 13, 4, 4, 13};

  tiny_fsm_ctrl dut (
    .clk            (clk),
    .fsm_rst        (fsm_rst),
    .step           (step),
    .run            (run),
    .halt           (halt),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .mem_ext_en     (mem_ext_en),
    .pc_out         (pc_out),
    .curr_instr_out (curr_instr_out),
    .next_instr_out (next_instr_out),
    .state_out      (state_out)
  );

  assign rd_data = rom[rd_addr];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Single-step one instruction; returns cycles spent outside IDLE.
  task automatic run_one(output int c);
    step = 1'b1;
    tick();
    step = 1'b0;
    c = 0;
    while (state_out != 3'd0 && c < 100) begin
      c++;
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < int'(ID); i++) rom[i] = I_NOP;
    rom[1] = I_LL;
    rom[2] = 32'h2000_0001;
    rom[3] = 32'h4000_0002;
    rom[4] = 32'h1000_0002;
    rom[5] = I_LL;
    rom[6] = 32'h2000_0001;
    rom[7] = 32'h0200_0000;
    rom[8] = 32'h0100_0100;
    rom[9]  = I_LL;
    rom[10] = I_LL;
    rom[11] = I_LL;
    for (int i = 0; i < 1024; i++) dut.DPRAM.mem[i] <= 8'(i);

    fsm_rst = 1'b1; step = 1'b0; run = 1'b0; halt = 1'b0; mem_ext_en = 1'b0;
    repeat (5) tick();
    check("rst_pc",    32'(pc_out), 32'd0);
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_curr",  curr_instr_out, 32'd0);
    check("rst_next",  next_instr_out, 32'd0);
    fsm_rst = 1'b0;

    // Single NOP step: FETCH, DECODE, EXEC, WB, then back to IDLE
    step = 1'b1;
    tick();
    check("s_fetch", 32'(state_out), 32'd1);
    check("s_fetch_addr", 32'(rd_addr), 32'd0);
    step = 1'b0;
    tick();
    check("s_decode", 32'(state_out), 32'd2);
    check("s_decode_addr", 32'(rd_addr), 32'd1);
    check("s_curr", curr_instr_out, I_NOP);
    tick();
    check("s_exec", 32'(state_out), 32'd3);
    check("s_next", next_instr_out, I_LL);
    tick();
    check("s_wb", 32'(state_out), 32'd5);
    tick();
    check("s_idle", 32'(state_out), 32'd0);
    check("s_pc", 32'(pc_out), 32'd1);

    // LOAD_LEFT @1 then SWAP_LEFT: active left = 1..8
    run_one(cyc);
    check("ll_lat", 32'(cyc), 32'd13);
    run_one(cyc);
    check("swap_lat", 32'(cyc), 32'd4);
    for (int i = 0; i < 8; i++)
      check($sformatf("left_act[%0d]", i), 32'(dut.left_act_q[i]), 32'(i + 1));

    // Load/swap both operands, MAC, store to 0x100
    for (int k = 0; k < 6; k++) begin
      run_one(cyc);
      check($sformatf("prog_lat[%0d]", k), 32'(cyc), 32'(exp_lat[k]));
    end
    check("prog_pc", 32'(pc_out), 32'd9);
    for (int i = 0; i < 8; i++)
      check($sformatf("mem[0x%0h]", 256 + i), 32'(dut.DPRAM.mem[256 + i]),
            32'(((i + 1) * (i + 2)) & 8'hFF));

    // Run with a halt pulse mid-MEM: instruction completes then stops
    run = 1'b1;
    cyc = 0;
    while (state_out != 3'd4 && cyc < 50) begin tick(); cyc++; end
    check("halt_in_mem", 32'(state_out), 32'd4);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    cyc = 0;
    while (state_out != 3'd0 && cyc < 50) begin tick(); cyc++; end
    run = 1'b0;
    check("halt_idle", 32'(state_out), 32'd0);
    check("halt_pc", 32'(pc_out), 32'd10);
    tick();
    check("halt_stays", 32'(state_out), 32'd0);

    // DPRAM reserved: DECODE stalls on a load
    mem_ext_en = 1'b1;
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    check("stall_enter", 32'(state_out), 32'd2);
    repeat (4) tick();
    check("stall_state", 32'(state_out), 32'd2);
    check("stall_pc", 32'(pc_out), 32'd10);
    mem_ext_en = 1'b0;
    cyc = 0;
    while (state_out != 3'd0 && cyc < 50) begin tick(); cyc++; end
    check("stall_rest", 32'(cyc), 32'd12);
    check("stall_pc_done", 32'(pc_out), 32'd11);
    run_one(cyc);
    check("post_stall_lat", 32'(cyc), 32'd13);

    // Free-run NOPs through the end of ROM: PC wraps 255 -> 0
    run = 1'b1;
    max_pc = 0;
    cyc = 0;
    tick();
    while (pc_out != 8'd0 && cyc < 2000) begin
      if (int'(pc_out) > max_pc) max_pc = int'(pc_out);
      tick();
      cyc++;
    end
    run = 1'b0;
    check("wrap_max", 32'(max_pc), 32'd255);
    check("wrap_pc", 32'(pc_out), 32'd0);
    cyc = 0;
    while (state_out != 3'd0 && cyc < 20) begin tick(); cyc++; end
    check("wrap_idle_pc", 32'(pc_out), 32'd1);

    // Reset in the middle of a MEM sequence
    step = 1'b1;
    tick();
    step = 1'b0;
    cyc = 0;
    while (state_out != 3'd4 && cyc < 20) begin tick(); cyc++; end
    check("mrst_in_mem", 32'(state_out), 32'd4);
    fsm_rst = 1'b1;
    tick();
    fsm_rst = 1'b0;
    check("mrst_state", 32'(state_out), 32'd0);
    check("mrst_pc", 32'(pc_out), 32'd0);
    check("mrst_curr", curr_instr_out, 32'd0);
    check("mrst_left_sh", 32'(dut.left_sh_q[7]), 32'd0);
    check("mrst_acc", dut.acc_q[1], 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
